// File: rtl/fnd_scan_controller_pkg.sv
// fnd_scan_controller_pkg: shared constants, segment table and scan state encoding
package fnd_scan_controller_pkg;
  localparam logic [6:0] SEG_BLANK = 7'h00;
  localparam logic [3:0] COM_OFF = 4'b1111;
  localparam logic [6:0] SEG_LUT [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                          7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
  typedef enum logic {S_SHOW, S_GUARD} state_t;
endpackage

// File: rtl/fnd_scan_controller_bin4_to_bcd.sv
// bin4_to_bcd: splits a 4-bit binary value into tens/ones decimal digits
module bin4_to_bcd (
  input  logic [3:0] v,
  output logic [3:0] tens,
  output logic [3:0] ones
);
  always_comb begin
    tens = (v > 4'd9) ? 4'd1 : 4'd0;
    ones = (v > 4'd9) ? v - 4'd10 : v;
  end
endmodule

// File: rtl/fnd_scan_controller.sv
// fnd_scan_controller: 4-digit multiplexed 7-segment driver showing two values as "AA BB"
module fnd_scan_controller
  import fnd_scan_controller_pkg::*;
#(
  parameter int SCAN_DIV  = 50000,
  parameter int GUARD_CYC = 500,
  parameter bit BLANK_LZ  = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       load_valid,
  output logic       load_ready,
  input  logic [3:0] val_a,
  input  logic [3:0] val_b,
  output logic [3:0] com,
  output logic [6:0] seg,
  output logic       frame_done
);
  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] SHOW_END = CW'(SCAN_DIV - GUARD_CYC);
  state_t state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic [1:0] idx, idx_nx;
  logic [3:0] disp_a, disp_b, pend_a, pend_b;
  logic pend_flag, slot_end, accept, blank;
  logic [3:0] tens_a, ones_a, tens_b, ones_b, digit, com_nx;
  logic [6:0] seg_nx;
  bin4_to_bcd u_bcd_a (.v(disp_a), .tens(tens_a), .ones(ones_a));
  bin4_to_bcd u_bcd_b (.v(disp_b), .tens(tens_b), .ones(ones_b));
  assign slot_end = cnt == LAST;
  assign frame_done = en & slot_end & (idx == 2'd3);
  assign load_ready = ~pend_flag;
  assign accept = load_valid & ~pend_flag;
  always_comb begin
    cnt_nx = en ? (slot_end ? '0 : cnt + 1'b1) : '0;
    idx_nx = en ? idx + {1'b0, slot_end} : 2'd0;
    state_nx = (cnt_nx < SHOW_END) ? S_SHOW : S_GUARD;
    digit = (idx == 2'd3) ? tens_a : (idx == 2'd2) ? ones_a : (idx == 2'd1) ? tens_b : ones_b;
    // odd slots carry tens digits, the only ones eligible for blanking
    blank = BLANK_LZ & idx[0] & (digit == 4'd0);
    com_nx = (en && state == S_SHOW) ? ~(4'b0001 << idx) : COM_OFF;
    seg_nx = (en && state == S_SHOW && !blank) ? SEG_LUT[digit] : SEG_BLANK;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cnt   <= '0;
      idx   <= 2'd0;
      state <= S_SHOW;
    end else begin
      cnt   <= cnt_nx;
      idx   <= idx_nx;
      state <= state_nx;
    end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      disp_a    <= 4'd0;
      disp_b    <= 4'd0;
      pend_a    <= 4'd0;
      pend_b    <= 4'd0;
      pend_flag <= 1'b0;
      com       <= COM_OFF;
      seg       <= SEG_BLANK;
    end else begin
      com <= com_nx;
      seg <= seg_nx;
      if (frame_done && pend_flag) begin
        disp_a    <= pend_a;
        disp_b    <= pend_b;
        pend_flag <= 1'b0;
      end else if (accept) begin
        pend_a    <= val_a;
        pend_b    <= val_b;
        pend_flag <= 1'b1;
      end
    end
endmodule

// File: tb/tb_fnd_scan_controller.sv
// tb_fnd_scan_controller: directed and random scan/load checks against a frame-position model
module tb_fnd_scan_controller;
  logic clk = 1'b0;
  logic rst, en, load_valid, load_ready, frame_done;
  logic [3:0] val_a, val_b, com;
  logic [6:0] seg;
  int compared = 0, mismatched = 0;
  int pos, da, db, pa, pb;
  bit pf;
  logic [3:0] ecom;
  logic [6:0] eseg;
  localparam logic [6:0] PAT [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                      7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
  always #5 clk = ~clk;
  fnd_scan_controller #(.SCAN_DIV(8), .GUARD_CYC(2), .BLANK_LZ(1'b1)) dut (
    .clk(clk), .rst(rst), .en(en), .load_valid(load_valid), .load_ready(load_ready),
    .val_a(val_a), .val_b(val_b), .com(com), .seg(seg), .frame_done(frame_done)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    assert (got === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h at pos=%0d t=%0t", tag, got, exp, pos, $time);
    end
  endtask
  task automatic model_reset();
    pos = 0; da = 0; db = 0; pa = 0; pb = 0; pf = 0;
    ecom = 4'hF; eseg = 7'h00;
  endtask
  // frame = 4 slots of 8 cycles; slot d shows digit d for 6 cycles then guards for 2
  task automatic cycle(input bit e, input bit lv, input int a, input int b);
    int d, v, dv;
    bit acc;
    en = e; load_valid = lv; val_a = 4'(a); val_b = 4'(b);
    #1;
    check("frame_done", {31'd0, frame_done}, {31'd0, e && pos == 31});
    check("load_ready", {31'd0, load_ready}, {31'd0, !pf});
    d = pos / 8;
    v = (d >= 2) ? da : db;
    dv = (d % 2 == 1) ? v / 10 : v % 10;
    if (e && pos % 8 < 6) begin
      ecom = ~4'(1 << d);
      eseg = (d % 2 == 1 && dv == 0) ? 7'h00 : PAT[dv];
    end else begin
      ecom = 4'hF;
      eseg = 7'h00;
    end
    acc = lv && !pf;
    if (e && pos == 31 && pf) begin da = pa; db = pb; pf = 0; end
    if (acc) begin pa = a; pb = b; pf = 1; end
    pos = e ? (pos + 1) % 32 : 0;
    @(posedge clk);
    #1;
    check("com", {28'd0, com}, {28'd0, ecom});
    check("seg", {25'd0, seg}, {25'd0, eseg});
  endtask
  initial begin
    rst = 1'b1; en = 1'b0; load_valid = 1'b0; val_a = 4'd0; val_b = 4'd0;
    model_reset();
    #12;
    check("rst_com", {28'd0, com}, 32'hF);
    check("rst_seg", {25'd0, seg}, 32'h0);
    check("rst_frame_done", {31'd0, frame_done}, 32'h0);
    check("rst_load_ready", {31'd0, load_ready}, 32'h1);
    rst = 1'b0;
    repeat (40) cycle(1, 0, 0, 0);
    while (pos != 12) cycle(1, 0, 0, 0);
    cycle(1, 1, 13, 7);
    repeat (3) cycle(1, 1, 5, 9);
    repeat (70) cycle(1, 0, 0, 0);
    while (pos != 31) cycle(1, 0, 0, 0);
    cycle(1, 1, 9, 12);
    repeat (64) cycle(1, 0, 0, 0);
    while (pos != 18) cycle(1, 0, 0, 0);
    repeat (5) cycle(0, 0, 0, 0);
    repeat (20) cycle(1, 0, 0, 0);
    cycle(1, 1, 4, 15);
    repeat (3) cycle(1, 0, 0, 0);
    #2 rst = 1'b1;
    #1;
    check("midrst_com", {28'd0, com}, 32'hF);
    check("midrst_seg", {25'd0, seg}, 32'h0);
    check("midrst_load_ready", {31'd0, load_ready}, 32'h1);
    model_reset();
    #1 rst = 1'b0;
    repeat (40) cycle(1, 0, 0, 0);
    repeat (600) cycle($urandom_range(0, 24) != 0, $urandom_range(0, 9) == 0,
                       $urandom_range(0, 15), $urandom_range(0, 15));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
